seq_pattern_tx: RTL and testbench

Bit-serial pattern transmitter. It drives a fixed bit pattern, 11001 by default, MSB first onto a single-bit line. The pattern is sent a programmable number of times, with an optional idle gap between repetitions. This is the transmit end of the serial sequence-detection link: its `dout` connects directly to the `din` of the non-overlapping 11001 Mealy detector. It is used both as the stimulus source and as the in-system pattern generator.

---
 rtl/seq_pattern_tx.sv | 169 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: bit-serial pattern transmitter.
//
// Shifts PATTERN out MSB first on dout, repeated a latched number of times.
// GAP idle cycles with dout=0 may be inserted between repetitions. Every
// output is a flop. Between repetitions the line carries only zeros, so a
// non-overlapping detector on dout counts exactly one hit per repetition.
//
// Parameters:
//   PAT_W   - pattern length in bits (>= 2)
//   PATTERN - pattern value, bit PAT_W-1 is sent first
//   CNT_W   - width of the repetition count
//   GAP     - idle cycles between consecutive repetitions (0..255)
//
// Ports:
//   clk      - single clock, rising edge
//   reset_n  - asynchronous active-low reset
//   start    - request a transmission, sampled only in idle
//   count    - number of repetitions, latched when start is accepted
//   abort    - synchronous cancel while shifting or in a gap
//   dout     - serial data, 0 whenever no pattern bit is presented
//   dout_vld - high while dout carries a pattern bit
//   sop      - high on the first bit of each repetition
//   busy     - high from the first bit up to the last bit/gap cycle
//   done     - one-cycle pulse after normal completion

module seq_pattern_tx #(
  parameter int unsigned      PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b11001,
  parameter int unsigned      CNT_W   = 4,
  parameter int unsigned      GAP     = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             dout,
  output logic             dout_vld,
  output logic             sop,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     IdxW   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(PAT_W - 1);
  localparam logic [7:0]      GapLd  = 8'(GAP);
  localparam logic            BitTop = PATTERN[PAT_W-1];

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap,
    StDone
  } state_e;

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;   // index of the bit currently on dout
  logic [CNT_W-1:0] rep_q;   // repetitions left, including the current one
  logic [7:0]       gap_q;   // gap cycles left, including the current one
  logic [IdxW-1:0]  idx_dn;

  always_comb begin
    idx_dn = idx_q - 1'b1;
  end

  // Output flops hold what the line shows in the cycle after each edge, so
  // every transition below also writes the outputs for the state it enters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      sop      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Line idles low unless a branch below presents a bit or a gap.
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      sop      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;

      unique case (state_q)
        StIdle: begin
          // abort is deliberately ignored here: start wins.
          if (start) begin
            if (count != '0) begin
              state_q  <= StShift;
              rep_q    <= count;
              idx_q    <= IdxTop;
              dout     <= BitTop;
              dout_vld <= 1'b1;
              sop      <= 1'b1;
              busy     <= 1'b1;
            end else begin
              // Zero repetitions: report completion without sending anything.
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
        end

        StShift: begin
          if (abort) begin
            state_q <= StIdle;
            idx_q   <= '0;
            rep_q   <= '0;
          end else if (idx_q != '0) begin
            idx_q    <= idx_dn;
            dout     <= PATTERN[idx_dn];
            dout_vld <= 1'b1;
            busy     <= 1'b1;
          end else begin
            // Last bit of this repetition is on the line now.
            rep_q <= rep_q - 1'b1;
            if (rep_q == CNT_W'(1)) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else if (GAP > 0) begin
              state_q <= StGap;
              gap_q   <= GapLd;
              busy    <= 1'b1;
            end else begin
              // Back-to-back repetition.
              idx_q    <= IdxTop;
              dout     <= BitTop;
              dout_vld <= 1'b1;
              sop      <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end

        StGap: begin
          if (abort) begin
            state_q <= StIdle;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
          end else if (gap_q == 8'd1) begin
            state_q  <= StShift;
            gap_q    <= '0;
            idx_q    <= IdxTop;
            dout     <= BitTop;
            dout_vld <= 1'b1;
            sop      <= 1'b1;
            busy     <= 1'b1;
          end else begin
            gap_q <= gap_q - 1'b1;
            busy  <= 1'b1;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx. Two instances: GAP=0 (inst 0, with a
// non-overlapping 11001 Mealy detector on its dout) and GAP=2 (inst 1).
// Stimulus pushes expected output events (cycle, flags); a forked monitor
// pops one whenever an instance shows dout_vld or done.

module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] start;
  logic [1:0] abort;
  logic [3:0] count;
  logic [1:0] dout, dout_vld, sop, busy, done;

  seq_pattern_tx #(.GAP(0)) u_dut0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start[0]),
    .count    (count),
    .abort    (abort[0]),
    .dout     (dout[0]),
    .dout_vld (dout_vld[0]),
    .sop      (sop[0]),
    .busy     (busy[0]),
    .done     (done[0])
  );

  seq_pattern_tx #(.GAP(2)) u_dut1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start[1]),
    .count    (count),
    .abort    (abort[1]),
    .dout     (dout[1]),
    .dout_vld (dout_vld[1]),
    .sop      (sop[1]),
    .busy     (busy[1]),
    .done     (done[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Non-overlapping 11001 Mealy detector on inst 0.
  logic [3:0]  det_hist;
  int unsigned det_len;
  logic        det_y;
  assign det_y = (det_len >= 4) && ({det_hist, dout[0]} == 5'b11001);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_hist <= '0;
      det_len  <= 0;
    end else if (det_y) begin
      det_hist <= '0;
      det_len  <= 0;
    end else begin
      det_hist <= {det_hist[2:0], dout[0]};
      if (det_len < 8) det_len <= det_len + 1;
    end
  end

  typedef struct {
    int         inst;
    int         cyc;
    logic [4:0] v;  // {dout_vld, dout, sop, busy, done}
  } evt_t;

  evt_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         y_tot = 0;
  int         busy_tot[2] = '{0, 0};
  logic [4:0] pat = 5'b11001;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", name, got, want, cyc);
    end
  endtask

  task automatic monitor_loop();
    evt_t e;
    forever begin
      @(negedge clk);
      if (det_y) y_tot++;
      for (int i = 0; i < 2; i++) begin
        if (busy[i]) busy_tot[i]++;
        check("dout_low_when_not_valid", 32'(dout[i] & ~dout_vld[i]), 0);
        if (dout_vld[i] || done[i]) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output inst=%0d cyc=%0d got=%b want=none", i, cyc,
                     {dout_vld[i], dout[i], sop[i], busy[i], done[i]});
          end else begin
            e = exp_q.pop_front();
            check("stream_inst", i, e.inst);
            check("stream_cycle", cyc, e.cyc);
            check("stream_flags", {27'd0, dout_vld[i], dout[i], sop[i], busy[i], done[i]},
                  {27'd0, e.v});
          end
        end
      end
    end
  endtask

  // Expected stream for cnt repetitions starting in cycle e. lim >= 0 keeps only
  // the first lim bits and no done (cut short by abort or reset).
  task automatic push_expect(input int inst, input int cnt, input int gap, input int e,
                             input int lim);
    evt_t ev;
    int   n = 0;
    for (int r = 0; r < cnt; r++) begin
      for (int b = 0; b < 5; b++) begin
        if (lim < 0 || n < lim) begin
          ev.inst = inst;
          ev.cyc  = e + r * (5 + gap) + b;
          ev.v    = {1'b1, pat[4-b], (b == 0), 1'b1, 1'b0};
          exp_q.push_back(ev);
        end
        n++;
      end
    end
    if (lim < 0) begin
      ev.inst = inst;
      ev.cyc  = e + cnt * 5 + ((cnt > 0) ? (cnt - 1) * gap : 0);
      ev.v    = 5'b00001;
      exp_q.push_back(ev);
    end
  endtask

  task automatic pulse_start(input int inst, input int cnt);
    count = 4'(cnt);
    start[inst] = 1'b1;
    @(negedge clk);
    start = '0;
  endtask

  task automatic drain(input string name);
    int b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  int e, b0, b1, y0;

  initial begin
    start   = '0;
    abort   = '0;
    count   = '0;
    reset_n = 1'b0;
    fork
      monitor_loop();
    join_none

    // Reset held while start toggles.
    repeat (4) begin
      @(negedge clk);
      start = ~start;
      check("reset_outputs", {22'd0, dout, dout_vld, sop, busy, done}, 0);
    end
    start = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_after_reset", {28'd0, dout, busy}, 0);
    end

    // Single repetition.
    e = cyc + 1;
    push_expect(0, 1, 0, e, -1);
    pulse_start(0, 1);
    drain("single_drain");

    // Back-to-back x3 with detector.
    b0 = busy_tot[0];
    y0 = y_tot;
    e = cyc + 1;
    push_expect(0, 3, 0, e, -1);
    pulse_start(0, 3);
    drain("b2b_drain");
    check("b2b_busy_cycles", busy_tot[0] - b0, 15);
    check("b2b_detector_hits", y_tot - y0, 3);

    // Gap insertion on the GAP=2 instance.
    b1 = busy_tot[1];
    e = cyc + 1;
    push_expect(1, 2, 2, e, -1);
    pulse_start(1, 2);
    drain("gap_drain");
    check("gap_busy_cycles", busy_tot[1] - b1, 12);

    // start while busy is ignored.
    b0 = busy_tot[0];
    y0 = y_tot;
    e = cyc + 1;
    push_expect(0, 2, 0, e, -1);
    pulse_start(0, 2);
    @(negedge clk);
    pulse_start(0, 5);
    drain("busy_start_drain");
    check("busy_start_busy_cycles", busy_tot[0] - b0, 10);
    check("busy_start_detector_hits", y_tot - y0, 2);

    // count = 0: done only.
    b0 = busy_tot[0];
    y0 = y_tot;
    e = cyc + 1;
    push_expect(0, 0, 0, e, -1);
    pulse_start(0, 0);
    drain("zero_count_drain");
    check("zero_count_busy_cycles", busy_tot[0] - b0, 0);
    check("zero_count_detector_hits", y_tot - y0, 0);

    // Abort on the 3rd bit.
    b0 = busy_tot[0];
    y0 = y_tot;
    e = cyc + 1;
    push_expect(0, 2, 0, e, 3);
    pulse_start(0, 2);
    repeat (2) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort = '0;
    check("abort_outputs", {28'd0, dout[0], busy[0], dout_vld[0], done[0]}, 0);
    drain("abort_drain");
    check("abort_busy_cycles", busy_tot[0] - b0, 3);
    check("abort_detector_hits", y_tot - y0, 0);

    // Asynchronous reset during the 4th bit, then a clean restart.
    e = cyc + 1;
    push_expect(0, 2, 0, e, 4);
    pulse_start(0, 2);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs", {27'd0, dout[0], dout_vld[0], sop[0], busy[0], done[0]}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drain("reset_mid_drain");
    y0 = y_tot;
    e = cyc + 1;
    push_expect(0, 1, 0, e, -1);
    pulse_start(0, 1);
    drain("restart_drain");
    check("restart_detector_hits", y_tot - y0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
